// File: rtl/jtframe_dump_sched.sv
// Frame-based capture scheduler: counts VS falling edges, waits for ROM
// download to end, then opens a single capture window of DUMP_LEN frames
// starting at START_FRAME (or immediately on a manual trigger).
module jtframe_dump_sched #(
   parameter int              CNTW        = 32,
   parameter logic [CNTW-1:0] START_FRAME = '0,
   parameter int unsigned     DUMP_LEN    = 16,
   parameter bit              WAIT_DL     = 1'b1
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            vs,
   input  logic            downloading,
   input  logic            trig,
   output logic [CNTW-1:0] frame_cnt,
   output logic            dump_en,
   output logic            dump_start,
   output logic            dump_stop,
   output logic [1:0]      st
);

   localparam logic [1:0] ST_WAIT_DL = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_DUMPING = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // State entered after reset and after a new download begins
   localparam logic [1:0] ST_IDLE = WAIT_DL ? ST_WAIT_DL : ST_ARMED;

   logic            vs_l_q;
   logic            dl_l_q;
   logic [CNTW-1:0] frame_cnt_q, frame_cnt_d;
   logic [1:0]      st_q, st_d;
   logic [31:0]     len_q, len_d;
   logic            dump_en_q, dump_en_d;
   logic            dump_start_q, dump_start_d;
   logic            dump_stop_q, dump_stop_d;

   logic tick;
   logic dl_fall;
   logic dl_rise;
   logic start_hit;

   assign tick    = vs_l_q & ~vs;
   assign dl_fall = dl_l_q & ~downloading;
   assign dl_rise = ~dl_l_q & downloading;

   // The frame compare uses the count before this tick's increment
   assign start_hit = (tick && frame_cnt_q == START_FRAME) || trig;

   // Input history for edge detection. These keep tracking the inputs through
   // reset so that no phantom edge is seen on the first cycle after it.
   always_ff @(posedge clk) begin
      vs_l_q <= vs;
      dl_l_q <= downloading;
   end

   // Frame counter: download end clears it, which takes priority over a tick
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (dl_fall) begin
         frame_cnt_d = '0;
      end else if (tick) begin
         frame_cnt_d = frame_cnt_q + 1'b1;
      end
   end

   // Window state machine; a new download aborts everything
   always_comb begin
      st_d         = st_q;
      len_d        = len_q;
      dump_en_d    = dump_en_q;
      dump_start_d = 1'b0;
      dump_stop_d  = 1'b0;
      if (dl_rise) begin
         st_d        = ST_IDLE;
         dump_en_d   = 1'b0;
         dump_stop_d = (st_q == ST_DUMPING);
      end else begin
         case (st_q)
            ST_WAIT_DL: begin
               if (dl_fall) st_d = ST_ARMED;
            end
            ST_ARMED: begin
               if (start_hit) begin
                  st_d         = ST_DUMPING;
                  dump_en_d    = 1'b1;
                  dump_start_d = 1'b1;
                  len_d        = DUMP_LEN;
               end
            end
            ST_DUMPING: begin
               // DUMP_LEN of zero keeps the window open indefinitely
               if (tick && DUMP_LEN != 0) begin
                  if (len_q == 32'd1) begin
                     st_d        = ST_DONE;
                     dump_en_d   = 1'b0;
                     dump_stop_d = 1'b1;
                  end
                  len_d = len_q - 32'd1;
               end
            end
            default: begin
               // DONE is terminal until reset or a new download
               st_d = st_q;
            end
         endcase
      end
   end

   // State registers with synchronous reset; reset drops the window silently
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q  <= '0;
         st_q         <= ST_IDLE;
         len_q        <= '0;
         dump_en_q    <= 1'b0;
         dump_start_q <= 1'b0;
         dump_stop_q  <= 1'b0;
      end else begin
         frame_cnt_q  <= frame_cnt_d;
         st_q         <= st_d;
         len_q        <= len_d;
         dump_en_q    <= dump_en_d;
         dump_start_q <= dump_start_d;
         dump_stop_q  <= dump_stop_d;
      end
   end

   assign frame_cnt  = frame_cnt_q;
   assign dump_en    = dump_en_q;
   assign dump_start = dump_start_q;
   assign dump_stop  = dump_stop_q;
   assign st         = st_q;

endmodule

// File: tb/tb_jtframe_dump_sched.sv
// Bench for jtframe_dump_sched: two instances (32-bit counter with a finite
// window, 4-bit counter with an endless window) checked every cycle against
// a frame-level model, plus literal expectations at the end of each scenario.
module tb_jtframe_dump_sched;

   logic clk = 1'b0;
   logic rst, vs, dl, trig, dl_b, trig_b;

   logic [31:0] fc_a;
   logic        en_a, start_a, stop_a;
   logic [1:0]  st_a;
   logic [3:0]  fc_b;
   logic        en_b, start_b, stop_b;
   logic [1:0]  st_b;

   int tests = 0;
   int fails = 0;
   int starts_a = 0, stops_a = 0, en_cyc_a = 0;
   int starts_b = 0, stops_b = 0;
   bit wrap_seen_b = 1'b0;
   logic [3:0] prev_fc_b = 4'd0;

   always #5 clk = ~clk;

   jtframe_dump_sched #(
      .CNTW(32), .START_FRAME(32'd3), .DUMP_LEN(2), .WAIT_DL(1'b1)
   ) dut_a (
      .clk(clk), .rst(rst), .vs(vs), .downloading(dl), .trig(trig),
      .frame_cnt(fc_a), .dump_en(en_a), .dump_start(start_a),
      .dump_stop(stop_a), .st(st_a)
   );

   jtframe_dump_sched #(
      .CNTW(4), .START_FRAME(4'd2), .DUMP_LEN(0), .WAIT_DL(1'b0)
   ) dut_b (
      .clk(clk), .rst(rst), .vs(vs), .downloading(dl_b), .trig(trig_b),
      .frame_cnt(fc_b), .dump_en(en_b), .dump_start(start_b),
      .dump_stop(stop_b), .st(st_b)
   );

   // Frame-level model: phase 0 waiting for download end, 1 armed,
   // 2 capturing with 'rem' frames left, 3 finished.
   typedef struct {
      bit          pv;
      bit          pdl;
      int unsigned cnt;
      int          ph;
      int unsigned rem;
      bit          en;
      bit          start;
      bit          stop;
   } mdl_t;

   mdl_t ma = '{default: 0};
   mdl_t mb = '{default: 0};

   function automatic mdl_t mstep(mdl_t m, bit r, bit v, bit d, bit t,
                                  int unsigned mask, int unsigned sf,
                                  int unsigned dlen, bit wdl);
      mdl_t n = m;
      bit frame    = m.pv && !v;
      bit dl_done  = m.pdl && !d;
      bit dl_began = !m.pdl && d;
      n.pv    = v;
      n.pdl   = d;
      n.start = 1'b0;
      n.stop  = 1'b0;
      if (r) begin
         n.cnt = 0;
         n.ph  = wdl ? 0 : 1;
         n.rem = 0;
         n.en  = 1'b0;
         return n;
      end
      if (dl_done)    n.cnt = 0;
      else if (frame) n.cnt = (m.cnt + 1) & mask;
      if (dl_began) begin
         n.stop = (m.ph == 2);
         n.ph   = wdl ? 0 : 1;
         n.en   = 1'b0;
      end else if (m.ph == 0 && dl_done) begin
         n.ph = 1;
      end else if (m.ph == 1 && ((frame && m.cnt == sf) || t)) begin
         n.ph    = 2;
         n.en    = 1'b1;
         n.start = 1'b1;
         n.rem   = dlen;
      end else if (m.ph == 2 && frame && dlen != 0) begin
         n.rem = m.rem - 1;
         if (n.rem == 0) begin
            n.ph   = 3;
            n.en   = 1'b0;
            n.stop = 1'b1;
         end
      end
      return n;
   endfunction

   // Advance both models on every rising edge, mirroring the sampled inputs
   initial begin
      forever begin
         @(posedge clk);
         ma = mstep(ma, rst, vs, dl,   trig,   32'hFFFF_FFFF, 3, 2, 1'b1);
         mb = mstep(mb, rst, vs, dl_b, trig_b, 32'h0000_000F, 2, 0, 1'b0);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // One clock: compare on the falling edge, then return just after the rising edge
   task automatic cyc();
      @(negedge clk);
      chk("a_cnt",   fc_a,            ma.cnt);
      chk("a_st",    {30'd0, st_a},   ma.ph);
      chk("a_en",    {31'd0, en_a},   {31'd0, ma.en});
      chk("a_start", {31'd0, start_a},{31'd0, ma.start});
      chk("a_stop",  {31'd0, stop_a}, {31'd0, ma.stop});
      chk("b_cnt",   {28'd0, fc_b},   mb.cnt);
      chk("b_st",    {30'd0, st_b},   mb.ph);
      chk("b_en",    {31'd0, en_b},   {31'd0, mb.en});
      chk("b_start", {31'd0, start_b},{31'd0, mb.start});
      chk("b_stop",  {31'd0, stop_b}, {31'd0, mb.stop});
      chk("a_pulse_excl", {31'd0, start_a & stop_a}, 32'd0);
      starts_a += int'(start_a);
      stops_a  += int'(stop_a);
      en_cyc_a += int'(en_a);
      starts_b += int'(start_b);
      stops_b  += int'(stop_b);
      if (prev_fc_b == 4'd15 && fc_b == 4'd0) wrap_seen_b = 1'b1;
      prev_fc_b = fc_b;
      @(posedge clk);
      #2;
   endtask

   task automatic vs_fall();
      vs = 1'b0;
      repeat (3) cyc();
      vs = 1'b1;
      repeat (3) cyc();
   endtask

   int s0, p0, e0;

   initial begin
      rst = 1'b1; vs = 1'b1; dl = 1'b1; trig = 1'b0; dl_b = 1'b0; trig_b = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();

      // 1: frames count during download, no window
      repeat (5) vs_fall();
      chk("t1_cnt", fc_a, 32'd5);
      chk("t1_st", {30'd0, st_a}, 32'd0);
      chk("t1_en", {31'd0, en_a}, 32'd0);
      chk("t1_model_cnt", ma.cnt, 32'd5);
      chk("t1_b_st", {30'd0, st_b}, 32'd2);
      chk("t1_b_cnt", {28'd0, fc_b}, 32'd5);

      // 2: download ends, window of two frames opens at frame 3
      dl = 1'b0;
      cyc(); cyc();
      chk("t2_clr", fc_a, 32'd0);
      chk("t2_armed", {30'd0, st_a}, 32'd1);
      s0 = starts_a; p0 = stops_a; e0 = en_cyc_a;
      repeat (8) vs_fall();
      chk("t2_st", {30'd0, st_a}, 32'd3);
      chk("t2_cnt", fc_a, 32'd8);
      chk("t2_starts", starts_a - s0, 32'd1);
      chk("t2_stops", stops_a - p0, 32'd1);
      chk("t2_en_cycles", en_cyc_a - e0, 32'd12);
      chk("t2_model_ph", ma.ph, 32'd3);

      // 3: re-arm via a new download, then trigger together with the matching tick
      p0 = stops_a;
      dl = 1'b1;
      cyc(); cyc();
      chk("t3_wait", {30'd0, st_a}, 32'd0);
      chk("t3_no_stop", stops_a - p0, 32'd0);
      dl = 1'b0;
      cyc(); cyc();
      repeat (3) vs_fall();
      chk("t3_cnt", fc_a, 32'd3);
      s0 = starts_a;
      trig = 1'b1; vs = 1'b0;
      repeat (3) cyc();
      trig = 1'b0; vs = 1'b1;
      repeat (3) cyc();
      chk("t3_single_start", starts_a - s0, 32'd1);
      chk("t3_st", {30'd0, st_a}, 32'd2);
      chk("t3_cnt_after", fc_a, 32'd4);

      // 4: download aborts the window, then it reopens at frame 3
      p0 = stops_a;
      dl = 1'b1;
      cyc(); cyc();
      chk("t4_stop", stops_a - p0, 32'd1);
      chk("t4_en", {31'd0, en_a}, 32'd0);
      chk("t4_st", {30'd0, st_a}, 32'd0);
      dl = 1'b0;
      cyc(); cyc();
      s0 = starts_a;
      repeat (3) vs_fall();
      chk("t4_armed", {30'd0, st_a}, 32'd1);
      chk("t4_no_early", starts_a - s0, 32'd0);
      vs_fall();
      chk("t4_reopen", {30'd0, st_a}, 32'd2);
      chk("t4_reopen_starts", starts_a - s0, 32'd1);
      chk("t4_cnt", fc_a, 32'd4);

      // 5: endless window on the 4-bit instance survives the counter wrap
      chk("t5_wrap", {31'd0, wrap_seen_b}, 32'd1);
      chk("t5_b_cnt", {28'd0, fc_b}, 32'd5);
      chk("t5_b_en", {31'd0, en_b}, 32'd1);
      chk("t5_b_stops", stops_b, 32'd0);
      chk("t5_b_starts", starts_b, 32'd1);

      // 6: reset in the middle of a window
      p0 = stops_a;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      chk("t6_en", {31'd0, en_a}, 32'd0);
      chk("t6_cnt", fc_a, 32'd0);
      chk("t6_st", {30'd0, st_a}, 32'd0);
      chk("t6_no_stop", stops_a - p0, 32'd0);
      chk("t6_b_en", {31'd0, en_b}, 32'd0);
      chk("t6_b_st", {30'd0, st_b}, 32'd1);
      chk("t6_b_stops", stops_b, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
